cordic_job_ctrl: RTL and testbench

Job controller that sits directly upstream of `cordic_comp` and also captures its results. It accepts one CORDIC job at a time over a valid/ready request port and registers the operands, mode and coordinate system onto the core's inputs. It sequences the core's reset/load and counts the core iterations. It then samples `x_out`/`y_out`/`z_out` into a result register held under a valid/ready handshake. With it, software and bench stimulus no longer hand-time core reset and iteration count.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_job_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cordic_job_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and controller state encoding for the CORDIC job path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

  // Coordinate-system codes as the core expects them on its coord input.
  localparam logic [1:0] CORDIC_LINEAR     = 2'b00;
  localparam logic [1:0] CORDIC_CIRCULAR   = 2'b01;
  localparam logic [1:0] CORDIC_RESERVED   = 2'b10;
  localparam logic [1:0] CORDIC_HYPERBOLIC = 2'b11;

  // Mode codes.
  localparam logic CORDIC_ROTATION  = 1'b0;
  localparam logic CORDIC_VECTORING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_RESULT
  } ctrl_state_t;

endpackage

// File: rtl/cordic_job_ctrl.sv
// Accepts one CORDIC job, drives cordic_comp through load/run, captures its results.
// Latency: result valid ITERATIONS+3 cycles after the request handshake (1 cycle for reserved coord).
// Backpressure: req_ready low whenever busy; result held stable in RESULT until res_ready.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         job request handshake
//   req_{x,y,z}_{whole,decimal} job operands; req_mode, req_coord job mode/coordinate system
//   core_{x,y,z}_{whole,decimal}, core_mode, core_coord  registered job fields to the core
//   core_rst                    core reset/load; high whenever the core is not running
//   core_{x,y,z}_out            core results
//   res_valid/res_ready         result handshake
//   res_{x,y,z}, res_mode, res_coord, res_err  captured result and job echo
//   busy                        controller is not idle
module cordic_job_ctrl
  import cordic_pkg::*;
#(
  parameter int WHOLE_BIT_WIDTH   = 2,   // at least 2
  parameter int DECIMAL_BIT_WIDTH = 6,
  parameter int ITERATIONS        = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH  // at least 1
) (
  input  logic                                         clk,
  input  logic                                         rst,

  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [WHOLE_BIT_WIDTH-1:0]                   req_x_whole,
  input  logic [WHOLE_BIT_WIDTH-1:0]                   req_y_whole,
  input  logic [WHOLE_BIT_WIDTH-1:0]                   req_z_whole,
  input  logic [DECIMAL_BIT_WIDTH-1:0]                 req_x_decimal,
  input  logic [DECIMAL_BIT_WIDTH-1:0]                 req_y_decimal,
  input  logic [DECIMAL_BIT_WIDTH-1:0]                 req_z_decimal,
  input  logic                                         req_mode,
  input  logic [1:0]                                   req_coord,

  output logic [WHOLE_BIT_WIDTH-1:0]                   core_x_whole,
  output logic [DECIMAL_BIT_WIDTH-1:0]                 core_x_decimal,
  output logic [WHOLE_BIT_WIDTH-1:0]                   core_y_whole,
  output logic [DECIMAL_BIT_WIDTH-1:0]                 core_y_decimal,
  output logic [WHOLE_BIT_WIDTH-1:0]                   core_z_whole,
  output logic [DECIMAL_BIT_WIDTH-1:0]                 core_z_decimal,
  output logic                                         core_mode,
  output logic [1:0]                                   core_coord,
  output logic                                         core_rst,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] core_x_out,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] core_y_out,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] core_z_out,

  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] res_x,
  output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] res_y,
  output logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] res_z,
  output logic                                         res_mode,
  output logic [1:0]                                   res_coord,
  output logic                                         res_err,
  output logic                                         busy
);

  localparam int W  = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH;
  localparam int CW = $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERATIONS - 1);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          reserved_job;

  assign accept       = (state_q == ST_IDLE) && req_valid;
  assign reserved_job = (req_coord == CORDIC_RESERVED);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // A reserved coordinate system never starts the core; the error is reported directly.
          state_d = reserved_job ? ST_RESULT : ST_LOAD;
        end
      end
      ST_LOAD:    state_d = ST_RUN;
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_d = ST_RESULT;
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    req_ready = 1'b0;
    core_rst  = 1'b1;
    res_valid = 1'b0;
    busy      = 1'b0;
    req_ready = (state_q == ST_IDLE) && !rst;
    // rst is ORed in so an abort during RUN freezes the core in the same cycle.
    core_rst  = (state_q != ST_RUN) || rst;
    res_valid = (state_q == ST_RESULT);
    busy      = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------- iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_LOAD) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------- job and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      core_x_whole   <= '0;
      core_x_decimal <= '0;
      core_y_whole   <= '0;
      core_y_decimal <= '0;
      core_z_whole   <= '0;
      core_z_decimal <= '0;
      core_mode      <= 1'b0;
      core_coord     <= 2'b00;
      res_x          <= '0;
      res_y          <= '0;
      res_z          <= '0;
      res_mode       <= 1'b0;
      res_coord      <= 2'b00;
      res_err        <= 1'b0;
    end else begin
      if (accept) begin
        core_x_whole   <= req_x_whole;
        core_x_decimal <= req_x_decimal;
        core_y_whole   <= req_y_whole;
        core_y_decimal <= req_y_decimal;
        core_z_whole   <= req_z_whole;
        core_z_decimal <= req_z_decimal;
        core_mode      <= req_mode;
        core_coord     <= req_coord;
        if (reserved_job) begin
          res_x     <= '0;
          res_y     <= '0;
          res_z     <= '0;
          res_mode  <= req_mode;
          res_coord <= req_coord;
          res_err   <= 1'b1;
        end
      end
      // core_rst is high in CAPTURE, so the core outputs hold the final iteration.
      if (state_q == ST_CAPTURE) begin
        res_x     <= W'(core_x_out);
        res_y     <= W'(core_y_out);
        res_z     <= W'(core_z_out);
        res_mode  <= core_mode;
        res_coord <= core_coord;
        res_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_job_ctrl.sv
// Directed bench for cordic_job_ctrl with a counting stand-in for cordic_comp.
// Latency: n/a.
// Backpressure: n/a.
module tb_cordic_job_ctrl;
  import cordic_pkg::*;

  localparam int WB = 2;
  localparam int DB = 6;
  localparam int W  = WB + DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [WB-1:0] req_x_whole, req_y_whole, req_z_whole;
  logic [DB-1:0] req_x_decimal, req_y_decimal, req_z_decimal;
  logic          req_mode;
  logic [1:0]    req_coord;
  logic [WB-1:0] core_x_whole, core_y_whole, core_z_whole;
  logic [DB-1:0] core_x_decimal, core_y_decimal, core_z_decimal;
  logic          core_mode;
  logic [1:0]    core_coord;
  logic          core_rst;
  logic [W-1:0]  core_x_out, core_y_out, core_z_out;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_x, res_y, res_z;
  logic          res_mode;
  logic [1:0]    res_coord;
  logic          res_err;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Stand-in core: counts edges spent out of reset; outputs are base +/- that count,
  // so a captured value pins down exactly how many iterations ran.
  logic [W-1:0] iter;
  logic [W-1:0] xbase, ybase, zbase;
  always @(posedge clk) begin
    if (core_rst) iter <= '0;
    else          iter <= iter + 8'd1;
  end
  assign core_x_out = xbase + iter;
  assign core_y_out = ybase + iter;
  assign core_z_out = zbase - iter;

  cordic_job_ctrl #(
    .WHOLE_BIT_WIDTH  (WB),
    .DECIMAL_BIT_WIDTH(DB),
    .ITERATIONS       (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_x_whole    (req_x_whole),
    .req_y_whole    (req_y_whole),
    .req_z_whole    (req_z_whole),
    .req_x_decimal  (req_x_decimal),
    .req_y_decimal  (req_y_decimal),
    .req_z_decimal  (req_z_decimal),
    .req_mode       (req_mode),
    .req_coord      (req_coord),
    .core_x_whole   (core_x_whole),
    .core_x_decimal (core_x_decimal),
    .core_y_whole   (core_y_whole),
    .core_y_decimal (core_y_decimal),
    .core_z_whole   (core_z_whole),
    .core_z_decimal (core_z_decimal),
    .core_mode      (core_mode),
    .core_coord     (core_coord),
    .core_rst       (core_rst),
    .core_x_out     (core_x_out),
    .core_y_out     (core_y_out),
    .core_z_out     (core_z_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_x          (res_x),
    .res_y          (res_y),
    .res_z          (res_z),
    .res_mode       (res_mode),
    .res_coord      (res_coord),
    .res_err        (res_err),
    .busy           (busy)
  );

  // Advance to 1 time unit after the next rising edge; cyc names the cycle now being observed.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic [WB-1:0] xw, input logic [DB-1:0] xd,
                         input logic [WB-1:0] yw, input logic [DB-1:0] yd,
                         input logic [WB-1:0] zw, input logic [DB-1:0] zd,
                         input logic md, input logic [1:0] cd);
    req_x_whole = xw; req_x_decimal = xd;
    req_y_whole = yw; req_y_decimal = yd;
    req_z_whole = zw; req_z_decimal = zd;
    req_mode = md; req_coord = cd;
  endtask

  // Offers the current job, waits (bounded) for acceptance, returns the handshake cycle.
  task automatic handshake(input string tag, output int a);
    int n;
    n = 0;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    a = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int a, a2, nh;
    int h[2];

    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    set_job('0, '0, '0, '0, '0, '0, 1'b0, 2'b00);
    xbase = '0; ybase = '0; zbase = '0;
    h[0] = 0; h[1] = 0;

    // ---------------- reset
    tick();
    chk("rst_core_rst",  {31'd0, core_rst},  32'd1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_err",   {31'd0, res_err},   32'd0);
    chk("rst_res_x",     {24'd0, res_x},     32'd0);
    chk("rst_core_x_dec",{26'd0, core_x_decimal}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_core_rst",  {31'd0, core_rst},  32'd1);

    // ---------------- circular rotation: x=0.100110, z=0.100001 (30 deg)
    xbase = 8'd47; ybase = 8'd24; zbase = 8'd33;
    set_job(2'b00, 6'b100110, 2'b00, 6'b000000, 2'b00, 6'b100001, CORDIC_ROTATION, CORDIC_CIRCULAR);
    res_ready = 1'b1;
    handshake("circ", a);
    chk("circ_load_core_rst", {31'd0, core_rst},       32'd1);
    chk("circ_load_busy",     {31'd0, busy},           32'd1);
    chk("circ_core_x_dec",    {26'd0, core_x_decimal}, 32'h26);
    chk("circ_core_z_dec",    {26'd0, core_z_decimal}, 32'h21);
    chk("circ_core_coord",    {30'd0, core_coord},     32'd1);
    repeat (8) begin
      tick();
      chk("circ_run_core_rst", {31'd0, core_rst}, 32'd0);
    end
    tick();
    chk("circ_capt_core_rst",  {31'd0, core_rst},  32'd1);
    chk("circ_capt_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    chk("circ_res_latency", cyc - a, 32'd11);
    chk("circ_res_valid",   {31'd0, res_valid}, 32'd1);
    chk("circ_res_x",       {24'd0, res_x},     32'h37);  // cos30 ~ 55/64
    chk("circ_res_y",       {24'd0, res_y},     32'h20);  // sin30 = 32/64
    chk("circ_res_z",       {24'd0, res_z},     32'h19);
    chk("circ_res_err",     {31'd0, res_err},   32'd0);
    chk("circ_res_mode",    {31'd0, res_mode},  32'd0);
    chk("circ_res_coord",   {30'd0, res_coord}, 32'd1);
    tick();
    chk("circ_consumed_valid", {31'd0, res_valid}, 32'd0);
    chk("circ_consumed_ready", {31'd0, req_ready}, 32'd1);

    // ---------------- hyperbolic vectoring with result backpressure
    xbase = 8'h30; ybase = 8'h10; zbase = 8'h40;
    set_job(2'b01, 6'b000000, 2'b00, 6'b100000, 2'b00, 6'b000000, CORDIC_VECTORING, CORDIC_HYPERBOLIC);
    res_ready = 1'b0;
    handshake("hyp", a);
    repeat (9) tick();
    chk("hyp_capt_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    chk("hyp_res_latency", cyc - a, 32'd11);
    chk("hyp_res_valid",   {31'd0, res_valid}, 32'd1);
    chk("hyp_res_x",       {24'd0, res_x},     32'h38);
    chk("hyp_res_y",       {24'd0, res_y},     32'h18);
    chk("hyp_res_z",       {24'd0, res_z},     32'h38);
    chk("hyp_res_mode",    {31'd0, res_mode},  32'd1);
    chk("hyp_res_coord",   {30'd0, res_coord}, 32'd3);

    // Second job (reserved coord) offered while the result is stalled.
    set_job(2'b10, 6'h15, 2'b01, 6'h0a, 2'b11, 6'h3f, CORDIC_VECTORING, CORDIC_RESERVED);
    req_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_res_x",     {24'd0, res_x},     32'h38);
      chk("bp_res_y",     {24'd0, res_y},     32'h18);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    chk("bp_job_not_taken", {30'd0, core_x_whole}, 32'd1);
    res_ready = 1'b1;
    tick();
    chk("bp_idle_res_valid", {31'd0, res_valid}, 32'd0);
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rsv_hs_core_rst",   {31'd0, core_rst},  32'd1);
    tick();
    req_valid = 1'b0;
    chk("rsv_res_valid",  {31'd0, res_valid},     32'd1);
    chk("rsv_res_err",    {31'd0, res_err},       32'd1);
    chk("rsv_res_x",      {24'd0, res_x},         32'd0);
    chk("rsv_res_y",      {24'd0, res_y},         32'd0);
    chk("rsv_res_z",      {24'd0, res_z},         32'd0);
    chk("rsv_res_mode",   {31'd0, res_mode},      32'd1);
    chk("rsv_res_coord",  {30'd0, res_coord},     32'd2);
    chk("rsv_core_rst",   {31'd0, core_rst},      32'd1);
    chk("rsv_core_x_whl", {30'd0, core_x_whole},  32'd2);
    tick();
    chk("rsv_consumed", {31'd0, res_valid}, 32'd0);
    chk("rsv_idle_core_rst", {31'd0, core_rst}, 32'd1);

    // ---------------- abort in RUN cycle 3
    xbase = 8'd47; ybase = 8'd24; zbase = 8'd33;
    set_job(2'b00, 6'b100110, 2'b00, 6'b000000, 2'b00, 6'b100001, CORDIC_ROTATION, CORDIC_CIRCULAR);
    handshake("abort", a);
    repeat (3) tick();
    chk("abort_run3_core_rst", {31'd0, core_rst}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_rst_core_rst", {31'd0, core_rst}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy",      {31'd0, busy},           32'd0);
    chk("abort_res_valid", {31'd0, res_valid},      32'd0);
    chk("abort_core_rst",  {31'd0, core_rst},       32'd1);
    chk("abort_core_xd",   {26'd0, core_x_decimal}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready},      32'd1);
    handshake("after_abort", a);
    repeat (10) tick();
    chk("after_abort_latency", cyc - a, 32'd11);
    chk("after_abort_valid",   {31'd0, res_valid}, 32'd1);
    chk("after_abort_res_x",   {24'd0, res_x},     32'h37);
    tick();

    // ---------------- back-to-back with res_ready tied high
    xbase = 8'h10; ybase = 8'h20; zbase = 8'h30;
    set_job(2'b01, 6'b000000, 2'b00, 6'b000000, 2'b00, 6'b100000, CORDIC_ROTATION, CORDIC_LINEAR);
    res_ready = 1'b1;
    req_valid = 1'b1;
    nh = 0;
    for (int i = 0; i < 60 && nh < 2; i++) begin
      if (req_ready) begin
        h[nh] = cyc;
        nh++;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("b2b_handshakes", nh, 32'd2);
    chk("b2b_gap", h[1] - h[0], 32'd12);
    a2 = h[1];
    repeat (10) tick();
    chk("b2b_latency",   cyc - a2, 32'd11);
    chk("b2b_res_valid", {31'd0, res_valid}, 32'd1);
    chk("b2b_res_x",     {24'd0, res_x},     32'h18);
    chk("b2b_res_coord", {30'd0, res_coord}, 32'd0);
    tick();
    chk("b2b_done_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
